// File: rtl/mem_access_if.sv
// Bundles the request, memory and response signals of the load/store sequencer.
// The unit sits on the slave modport; the pipeline, memory and writeback side use the master modport.
interface mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_byte;
   logic        req_hi;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        mem_write_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_we, req_byte, req_hi, req_addr, req_wdata,
      input  mem_read_data, rsp_ready,
      output req_ready, mem_write_en, mem_addr, mem_write_data,
      output rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_we, req_byte, req_hi, req_addr, req_wdata,
      output mem_read_data, rsp_ready,
      input  req_ready, mem_write_en, mem_addr, mem_write_data,
      input  rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between EX/MEM and the 16x16 data memory; byte stores use read-modify-write.
// Optional MEM_ACCESS_SIGN_EXT_EN: byte loads sign-extend instead of zero-extend.
//
// state  | meaning
// IDLE   | ready for a request; out-of-range addresses go straight to RESP
// ACCESS | memory addressed: loads capture data, word store writes, byte store reads old word
// WRITE  | byte store writes the merged word
// RESP   | response presented until rsp_ready
module mem_access_unit #(
   parameter int DEPTH = 16
) (
   input logic         clk,
   input logic         reset,
   mem_access_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      stateQ, stateD;
   logic        weQ, byteQ, hiQ;
   logic [15:0] addrQ, wdataQ, oldQ;
   logic [15:0] rspDataQ;
   logic        rspErrQ;

   logic        outOfRange;
   logic [7:0]  selByte;
   logic [15:0] loadByte;
   logic [15:0] mergedData;
   logic        memWe;
   logic [15:0] memWd;
   logic        reqReady;
   logic        rspValid;

   assign outOfRange = ({16'h0000, bus.req_addr} >= 32'(DEPTH));
   assign selByte    = hiQ ? bus.mem_read_data[15:8] : bus.mem_read_data[7:0];
`ifdef MEM_ACCESS_SIGN_EXT_EN
   assign loadByte   = {{8{selByte[7]}}, selByte};
`else
   assign loadByte   = {8'h00, selByte};
`endif
   assign mergedData = hiQ ? {wdataQ[7:0], oldQ[7:0]} : {oldQ[15:8], wdataQ[7:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stateQ <= IDLE;
      else       stateQ <= stateD;
   end

   always_comb begin
      stateD   = stateQ;
      memWe    = 1'b0;
      memWd    = wdataQ;
      reqReady = 1'b0;
      rspValid = 1'b0;
      case (stateQ)
         IDLE: begin
            reqReady = 1'b1;
            if (bus.req_valid) stateD = outOfRange ? RESP : ACCESS;
         end
         ACCESS: begin
            memWe  = weQ & ~byteQ;
            stateD = (weQ & byteQ) ? WRITE : RESP;
         end
         WRITE: begin
            memWe  = 1'b1;
            memWd  = mergedData;
            stateD = RESP;
         end
         RESP: begin
            rspValid = 1'b1;
            if (bus.rsp_ready) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   // Request fields and response data; the response regs only change outside RESP, so they hold under backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weQ      <= 1'b0;
         byteQ    <= 1'b0;
         hiQ      <= 1'b0;
         addrQ    <= 16'h0000;
         wdataQ   <= 16'h0000;
         oldQ     <= 16'h0000;
         rspDataQ <= 16'h0000;
         rspErrQ  <= 1'b0;
      end else begin
         if (stateQ == IDLE && bus.req_valid) begin
            weQ      <= bus.req_we;
            byteQ    <= bus.req_byte;
            hiQ      <= bus.req_hi;
            addrQ    <= bus.req_addr;
            wdataQ   <= bus.req_wdata;
            rspDataQ <= 16'h0000;
            rspErrQ  <= outOfRange;
         end
         if (stateQ == ACCESS) begin
            if (!weQ)         rspDataQ <= byteQ ? loadByte : bus.mem_read_data;
            if (weQ && byteQ) oldQ     <= bus.mem_read_data;
         end
      end
   end

   assign bus.req_ready      = reqReady;
   assign bus.mem_write_en   = memWe;
   assign bus.mem_addr       = addrQ;
   assign bus.mem_write_data = memWd;
   assign bus.rsp_valid      = rspValid;
   assign bus.rsp_data       = rspDataQ;
   assign bus.rsp_err        = rspErrQ;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 16-word behavioural memory.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mem_access_if bus();

   mem_access_unit #(.DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef MEM_ACCESS_SIGN_EXT_EN
   localparam logic [15:0] EXP_HI_LOAD = 16'hFFA0;
`else
   localparam logic [15:0] EXP_HI_LOAD = 16'h00A0;
`endif

   logic [15:0] mem [16] = '{16'h0000, 16'h0000, 16'h2222, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h4455,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000};
   int          wrCount = 0;
   logic [15:0] lastWrAddr = 16'h0000;

   assign bus.mem_read_data = (bus.mem_addr < 16'd16) ? mem[bus.mem_addr[3:0]] : 16'h0000;

   always @(posedge clk) begin
      if (bus.mem_write_en) begin
         if (bus.mem_addr < 16'd16) mem[bus.mem_addr[3:0]] = bus.mem_write_data;
         wrCount    = wrCount + 1;
         lastWrAddr = bus.mem_addr;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, take the accept edge, then count edges until rsp_valid (bounded).
   task automatic doReq(input logic we, input logic byteAcc, input logic hi,
                        input logic [15:0] addr, input logic [15:0] wdata, output int lat);
      check("req_ready before accept", {15'h0, bus.req_ready}, 16'h0001);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_byte  = byteAcc;
      bus.req_hi    = hi;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic finishResp();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("idle after handshake", {14'h0, bus.req_ready, bus.rsp_valid}, 16'h0002);
   endtask

   initial begin
      int lat;
      int wr0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_hi    = 1'b0;
      bus.req_addr  = 16'h0000;
      bus.req_wdata = 16'h0000;
      bus.rsp_ready = 1'b0;
      #12 reset = 1'b0;
      tick();
      tick();

      // Asynchronous reset between edges
      reset = 1'b1;
      #2;
      check("rst req_ready",      {15'h0, bus.req_ready},    16'h0001);
      check("rst rsp_valid",      {15'h0, bus.rsp_valid},    16'h0000);
      check("rst rsp_data",       bus.rsp_data,              16'h0000);
      check("rst rsp_err",        {15'h0, bus.rsp_err},      16'h0000);
      check("rst mem_write_en",   {15'h0, bus.mem_write_en}, 16'h0000);
      check("rst mem_addr",       bus.mem_addr,              16'h0000);
      check("rst mem_write_data", bus.mem_write_data,        16'h0000);
      tick();
      reset = 1'b0;
      tick();

      // Word load
      wr0 = wrCount;
      doReq(1'b0, 1'b0, 1'b0, 16'd2, 16'h0000, lat);
      check("wload latency", 16'(lat), 16'd2);
      check("wload data",    bus.rsp_data, 16'h2222);
      check("wload err",     {15'h0, bus.rsp_err}, 16'h0000);
      check("wload no write", 16'(wrCount - wr0), 16'd0);
      finishResp();

      // Word store then load
      wr0 = wrCount;
      doReq(1'b1, 1'b0, 1'b0, 16'd5, 16'hBEEF, lat);
      check("wstore latency", 16'(lat), 16'd2);
      check("wstore writes",  16'(wrCount - wr0), 16'd1);
      check("wstore addr",    lastWrAddr, 16'd5);
      check("wstore mem",     mem[5], 16'hBEEF);
      check("wstore rsp_data", bus.rsp_data, 16'h0000);
      check("wstore rsp_err", {15'h0, bus.rsp_err}, 16'h0000);
      finishResp();
      doReq(1'b0, 1'b0, 1'b0, 16'd5, 16'h0000, lat);
      check("wload5 data", bus.rsp_data, 16'hBEEF);
      finishResp();

      // Byte store to upper lane, then byte loads of both lanes
      wr0 = wrCount;
      doReq(1'b1, 1'b1, 1'b1, 16'd7, 16'h00A0, lat);
      check("bstore latency", 16'(lat), 16'd3);
      check("bstore writes",  16'(wrCount - wr0), 16'd1);
      check("bstore mem",     mem[7], 16'hA055);
      check("bstore rsp_data", bus.rsp_data, 16'h0000);
      finishResp();
      doReq(1'b0, 1'b1, 1'b1, 16'd7, 16'h0000, lat);
      check("bload hi latency", 16'(lat), 16'd2);
      check("bload hi data",    bus.rsp_data, EXP_HI_LOAD);
      finishResp();
      doReq(1'b0, 1'b1, 1'b0, 16'd7, 16'h0000, lat);
      check("bload lo data", bus.rsp_data, 16'h0055);
      finishResp();

      // Out-of-range store with backpressure
      wr0 = wrCount;
      doReq(1'b1, 1'b0, 1'b0, 16'd16, 16'h1234, lat);
      check("err latency", 16'(lat), 16'd1);
      for (int i = 0; i < 3; i++) begin
         check("err held valid", {15'h0, bus.rsp_valid}, 16'h0001);
         check("err held flag",  {15'h0, bus.rsp_err},   16'h0001);
         check("err held data",  bus.rsp_data,           16'h0000);
         check("err busy ready", {15'h0, bus.req_ready}, 16'h0000);
         tick();
      end
      check("err no write", 16'(wrCount - wr0), 16'd0);
      finishResp();
      doReq(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, lat);
      check("err ffff latency", 16'(lat), 16'd1);
      check("err ffff flag", {15'h0, bus.rsp_err}, 16'h0001);
      finishResp();

      // Reset while in WRITE of a byte store
      wr0 = wrCount;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_byte  = 1'b1;
      bus.req_hi    = 1'b0;
      bus.req_addr  = 16'd7;
      bus.req_wdata = 16'h0011;
      tick();
      bus.req_valid = 1'b0;
      tick();
      check("write phase we",   {15'h0, bus.mem_write_en}, 16'h0001);
      check("write phase data", bus.mem_write_data, 16'hA011);
      reset = 1'b1;
      #1;
      check("midrst we",        {15'h0, bus.mem_write_en}, 16'h0000);
      check("midrst rsp_valid", {15'h0, bus.rsp_valid},    16'h0000);
      check("midrst req_ready", {15'h0, bus.req_ready},    16'h0001);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("midrst mem",       mem[7], 16'hA055);
      check("midrst no write",  16'(wrCount - wr0), 16'd0);
      check("midrst no rsp",    {15'h0, bus.rsp_valid}, 16'h0000);

      doReq(1'b0, 1'b0, 1'b0, 16'd5, 16'h0000, lat);
      check("post reset load", bus.rsp_data, 16'hBEEF);
      finishResp();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
